// File: rtl/slc3_muldiv_if.sv
// Request/response bundle between the ISDU side and the mul/div unit.
// Handshake: the master raises Start for one cycle with Op_Div, A and B
// valid; the unit accepts it only when idle (Busy = 0, Done = 0), keeps
// Busy high while working, then pulses Done for exactly one cycle with
// Result and DivByZero valid. Result and DivByZero then hold until the
// next accepted Start.
interface slc3_muldiv_if #(
  parameter int WIDTH = 16
);
  logic             Start;
  logic             Op_Div;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Result;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Start, Op_Div, A, B,
    input  Result, Busy, Done, DivByZero
  );

  modport slave (
    input  Start, Op_Div, A, B,
    output Result, Busy, Done, DivByZero
  );
endinterface

// File: rtl/slc3_muldiv_unit.sv
// Iterative signed multiply / divide unit for the SLC-3 MUL and DIV
// instructions. Operands are converted to magnitudes on acceptance, a
// WIDTH-cycle unsigned shift-add or restoring-divide loop runs, and the
// sign is applied in a single fixup cycle. Latency is fixed for all
// operands: Busy in cycles 1..WIDTH+1, Done in cycle WIDTH+2.
module slc3_muldiv_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  slc3_muldiv_if.slave      bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_FIXUP   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               op_div_r;
  logic               neg_r;
  logic [WIDTH-1:0]   acc;     // MUL: product high half; DIV: partial remainder
  logic [WIDTH-1:0]   q;       // MUL: multiplier / product low half; DIV: dividend / quotient
  logic [WIDTH-1:0]   mag_b;   // |B|: multiplicand or divisor
  logic [WIDTH-1:0]   result_r;
  logic               dbz_r;

  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   acc_nx, q_nx;
  logic               last_iter;

  // Magnitudes of the incoming operands; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  assign mag_a_in  = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
  assign mag_b_in  = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // One iteration of the shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, mag_b} : '0);
    div_shift = {acc, q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    // Only needed when div_ge holds, where the difference fits in WIDTH bits.
    div_sub   = div_shift[WIDTH-1:0] - mag_b;
    acc_nx    = acc;
    q_nx      = q;
    if (op_div_r) begin
      acc_nx = div_ge ? div_sub : div_shift[WIDTH-1:0];
      q_nx   = {q[WIDTH-2:0], div_ge};
    end else begin
      acc_nx = mul_sum[WIDTH:1];
      q_nx   = {mul_sum[0], q[WIDTH-1:1]};
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; Start is only honoured in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (bus.Start) state_nx = S_COMPUTE;
      S_COMPUTE: if (last_iter) state_nx = S_FIXUP;
      S_FIXUP:   state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Datapath registers: operand capture, iteration, sign fixup.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt      <= '0;
      op_div_r <= 1'b0;
      neg_r    <= 1'b0;
      acc      <= '0;
      q        <= '0;
      mag_b    <= '0;
      result_r <= '0;
      dbz_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            op_div_r <= bus.Op_Div;
            neg_r    <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            q        <= mag_a_in;
            mag_b    <= mag_b_in;
            acc      <= '0;
            cnt      <= '0;
            dbz_r    <= 1'b0;
          end
        end
        S_COMPUTE: begin
          cnt <= cnt + 1'b1;
          acc <= acc_nx;
          q   <= q_nx;
        end
        S_FIXUP: begin
          if (op_div_r && (mag_b == '0)) begin
            result_r <= '1;
            dbz_r    <= 1'b1;
          end else begin
            result_r <= neg_r ? (~q + 1'b1) : q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Result    = result_r;
  assign bus.DivByZero = dbz_r;
  assign bus.Busy      = (state == S_COMPUTE) || (state == S_FIXUP);
  assign bus.Done      = (state == S_DONE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_slc3_muldiv_unit.sv
// Directed and randomised stimulus for slc3_muldiv_unit with a result
// scoreboard fed when each request is driven.
module tb_slc3_muldiv_unit;

  logic       Clk;
  logic       Reset;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // {DivByZero, Result} expected per accepted request.
  logic [16:0] exp_q[$];

  slc3_muldiv_if #(.WIDTH(16)) bus ();

  slc3_muldiv_unit #(.WIDTH(16), .CNT_W(5)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and global time limit.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!op) r = sa * sb;
    else if (b == 16'h0) return {1'b1, 16'hFFFF};
    else r = sa / sb;
    return {1'b0, r[15:0]};
  endfunction

  // Drive one request sampled at the next rising edge (edge 0).
  task automatic start_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                          input logic [16:0] exp);
    @(negedge Clk);
    bus.Start  = 1'b1;
    bus.Op_Div = op;
    bus.A      = a;
    bus.B      = b;
    exp_q.push_back(exp);
    @(posedge Clk);
    #1;
    bus.Start  = 1'b0;
    bus.Op_Div = 1'($urandom_range(0, 1));
    bus.A      = 16'($urandom_range(0, 65535));
    bus.B      = 16'($urandom_range(0, 65535));
  endtask

  // Follow cycles 1..18 of an operation; optionally pulse a stray Start.
  task automatic run_op(input string tag, input int inj_cycle, input logic inj_op,
                        input logic [15:0] inj_a, input logic [15:0] inj_b);
    logic [16:0] exp;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
      check({tag, "_busy"}, 32'(bus.Busy), 32'(cyc <= 17));
      check({tag, "_done"}, 32'(bus.Done), 32'(cyc == 18));
      if (cyc == 18) begin
        if (exp_q.size() == 0) begin
          check({tag, "_queue"}, 32'(0), 32'(1));
        end else begin
          exp = exp_q.pop_front();
          check({tag, "_result"}, 32'(bus.Result), 32'(exp[15:0]));
          check({tag, "_dbz"}, 32'(bus.DivByZero), 32'(exp[16]));
        end
      end
      if (cyc == inj_cycle) begin
        bus.Start  = 1'b1;
        bus.Op_Div = inj_op;
        bus.A      = inj_a;
        bus.B      = inj_b;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic op, input logic [15:0] a,
                       input logic [15:0] b, input logic [16:0] exp);
    start_op(op, a, b, exp);
    run_op(tag, 0, 1'b0, 16'h0, 16'h0);
  endtask

  // Directed sequence.
  initial begin
    int done_seen;
    logic       rop;
    logic [15:0] ra, rb;

    Reset      = 1'b1;
    bus.Start  = 1'b0;
    bus.Op_Div = 1'b0;
    bus.A      = 16'h0;
    bus.B      = 16'h0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_result", 32'(bus.Result), 32'h0);
    check("rst_busy", 32'(bus.Busy), 32'h0);
    check("rst_done", 32'(bus.Done), 32'h0);
    check("rst_dbz", 32'(bus.DivByZero), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    Reset = 1'b0;

    do_op("mul_7_m3", 1'b0, 16'd7, 16'hFFFD, {1'b0, 16'hFFEB});
    do_op("mul_300", 1'b0, 16'd300, 16'd300, {1'b0, 16'h5F90});
    do_op("mul_min", 1'b0, 16'h8000, 16'hFFFF, {1'b0, 16'h8000});
    do_op("div_100_7", 1'b1, 16'd100, 16'd7, {1'b0, 16'd14});
    do_op("div_m7_2", 1'b1, 16'hFFF9, 16'd2, {1'b0, 16'hFFFD});
    do_op("div_7_m2", 1'b1, 16'd7, 16'hFFFE, {1'b0, 16'hFFFD});
    do_op("div_min", 1'b1, 16'h8000, 16'hFFFF, {1'b0, 16'h8000});
    do_op("div_zero", 1'b1, 16'd5, 16'd0, {1'b1, 16'hFFFF});
    do_op("mul_after_dbz", 1'b0, 16'd2, 16'd3, {1'b0, 16'd6});

    // Stray Start while busy must be ignored.
    start_op(1'b0, 16'd4, 16'd5, {1'b0, 16'd20});
    run_op("mul_ignore", 5, 1'b1, 16'd9, 16'd3);
    // Back-to-back request in the cycle after Done; stray Start in DONE.
    start_op(1'b1, 16'd9, 16'd3, {1'b0, 16'd3});
    run_op("div_b2b", 18, 1'b0, 16'd1, 16'd1);
    do_op("mul_after_done_start", 1'b0, 16'hFFF6, 16'd11, {1'b0, 16'hFF92});

    // Randomised operands checked against the arithmetic model.
    for (int i = 0; i < 6; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = 16'($urandom_range(0, 65535));
      rb  = (i == 5) ? 16'($urandom_range(0, 31)) : 16'($urandom_range(0, 65535));
      do_op("rand", rop, ra, rb, model(rop, ra, rb));
    end

    // Reset in cycle 8 aborts the operation with no Done.
    start_op(1'b0, 16'd12, 16'd12, {1'b0, 16'd144});
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge Clk);
      check("abort_busy", 32'(bus.Busy), 32'h1);
      if (cyc == 8) begin
        Reset = 1'b1;
        exp_q.delete();
      end
    end
    @(negedge Clk);
    check("abort_result", 32'(bus.Result), 32'h0);
    check("abort_busy0", 32'(bus.Busy), 32'h0);
    check("abort_done", 32'(bus.Done), 32'h0);
    check("abort_dbz", 32'(bus.DivByZero), 32'h0);
    check("abort_state", 32'(dbg_state), 32'h0);
    Reset = 1'b0;
    done_seen = 0;
    repeat (25) begin
      @(negedge Clk);
      if (bus.Done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'h0);
    do_op("mul_12_12", 1'b0, 16'd12, 16'd12, {1'b0, 16'd144});

    // Reset and Start on the same edge: Start is discarded.
    @(negedge Clk);
    Reset      = 1'b1;
    bus.Start  = 1'b1;
    bus.Op_Div = 1'b0;
    bus.A      = 16'd3;
    bus.B      = 16'd3;
    @(negedge Clk);
    Reset     = 1'b0;
    bus.Start = 1'b0;
    check("rst_start_busy", 32'(bus.Busy), 32'h0);
    check("rst_start_state", 32'(dbg_state), 32'h0);
    @(negedge Clk);
    check("rst_start_busy2", 32'(bus.Busy), 32'h0);
    check("rst_start_result", 32'(bus.Result), 32'h0);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slc3_muldiv_unit.md
Name: slc3_muldiv_unit

Overview:
- Iterative signed multiply/divide execution unit for the SLC-3 datapath.
- Serves the MUL (opcode 1111) and DIV (opcode 1110) instructions, both in register and imm5 form.
- Sits downstream of instruction decode / ISDU, beside the ALU. The ISDU supplies SR1 and SR2-or-SEXT(imm5) operands, pulses Start, and waits in a stall state until Done. Result then drives the bus for the DR write and the NZP update.

Parameters:
- WIDTH, 16, operand and result width in bits (two's complement).
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk, input, 1, system clock; all state updates on the rising edge.
- Reset, input, 1, synchronous, active-high; one clock, one synchronous active-high reset.
- Start, input, 1, request pulse; sampled only in IDLE.
- Op_Div, input, 1, 0 = MUL (A*B), 1 = DIV (A/B); latched with Start.
- A, input, WIDTH, signed operand SR1 / dividend; latched with Start.
- B, input, WIDTH, signed operand SR2 or SEXT(imm5) / divisor; latched with Start.
- Result, output, WIDTH, signed result; held stable from Done until the next accepted Start.
- Busy, output, 1, high from the cycle after Start is accepted through the FIXUP cycle.
- Done, output, 1, single-cycle completion pulse.
- DivByZero, output, 1, set with Done when DIV has B = 0; cleared on the next accepted Start.

Behaviour:
- Reset values: Result = 0, Busy = 0, Done = 0, DivByZero = 0; state = IDLE, counter = 0.
- State machine (all transitions on the clock edge):
  - IDLE: if Start = 1, latch Op_Div, the signs of A and B, |A| and |B| (unsigned WIDTH bits; |-32768| = 16'h8000), clear the accumulator and DivByZero, set counter = 0, go to COMPUTE. If Start = 0, stay.
  - COMPUTE: exactly WIDTH cycles; counter increments each cycle; leave when counter = WIDTH-1.
    - MUL: shift-add over 2*WIDTH-bit partial product, one multiplier bit per cycle, LSB first.
    - DIV: restoring division, one quotient bit per cycle, MSB first. Subtract if remainder >= divisor, else restore.
  - FIXUP (1 cycle): apply sign, write Result, go to DONE.
    - MUL: Result = low WIDTH bits of the product, negated if sign(A) XOR sign(B). Truncation, no overflow flag.
    - DIV: quotient truncates toward zero, negated if sign(A) XOR sign(B). Remainder is discarded.
    - DIV with B = 0: Result = 16'hFFFF and DivByZero = 1. Latency is unchanged; no early exit.
    - DIV 16'h8000 / 16'hFFFF: Result = 16'h8000 (wraps, no flag).
  - DONE (1 cycle): Done = 1, Busy = 0, then go to IDLE.
- Latency: Start is sampled at edge 0; Busy is high in cycles 1..17; Done is high in cycle 18 only. Fixed for every operand value and op.
- Start while not in IDLE is ignored, and operands are not re-latched. Start in the DONE cycle is also ignored. Start may be accepted in the cycle right after Done (back-to-back throughput is 19 cycles).
- A and B may change freely after the accepting edge.
- Reset mid-operation: state returns to IDLE on that edge and all outputs take their reset values. No Done is issued for the aborted operation.
- Reset and Start high on the same edge: Reset wins; the Start is discarded.
- Busy and Done are never high in the same cycle.

Test Plan:
- Reset, then MUL A = 7, B = -3 (16'hFFFD) -> Done in cycle 18 exactly, Result = 16'hFFEB, DivByZero = 0, Busy high in cycles 1..17 only.
- MUL A = 300, B = 300 -> Result = 16'h5F90 (90000 mod 65536). MUL A = 16'h8000, B = 16'hFFFF -> Result = 16'h8000.
- DIV A = 100, B = 7 -> Result = 14. DIV A = -7, B = 2 -> Result = 16'hFFFD (-3). DIV A = 7, B = -2 -> 16'hFFFD.
- DIV A = 5, B = 0 -> Result = 16'hFFFF and DivByZero = 1 at Done in cycle 18. The next MUL 2*3 -> DivByZero = 0, Result = 6.
- MUL 4*5 started, then Start with DIV 9/3 and changed operands pulsed in cycle 5 -> ignored, Result = 20. DIV issued the cycle after Done -> Result = 3 exactly 18 cycles later.
- MUL 12*12 started, Reset asserted in cycle 8 -> all outputs 0 from the next edge, no Done pulse. A fresh MUL 12*12 then yields Result = 144 on schedule.
